// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath interface.
//   - funct codes understood by the datapath, plus the idle NOP code
//   - sequencer state enum
//   - funct classification helpers (also used by ALUControl)
package alu_pkg;

  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;

  // Decoded by no datapath unit, so driving it leaves the divider idle.
  localparam logic [5:0] NOP_FUNCT = 6'b111111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    DIV_WAIT = 2'd2,
    RESP     = 2'd3
  } seq_state_t;

  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_SLL, FN_DIVU, FN_MFHI, FN_MFLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic funct_is_div(input logic [5:0] f);
    return (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issuing end of the ALU datapath interface.
// Accepts a request (funct, a, b) over valid/ready, drives the datapath's
// dataA/dataB/Signal, holds them for the operation latency (multi-cycle for
// DIVU), captures the datapath Output and returns it over valid/ready.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_funct/a/b       operation code and operands
//   alu_dataA/B/signal  registered drive to the datapath
//   alu_result          datapath Output
//   rsp_valid/rsp_ready response handshake
//   rsp_data/funct/err  result, funct of completed op, unsupported-funct flag
//   busy                high in any state other than IDLE
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT    = 2,
  parameter int unsigned DIV_CYCLES = 34,
  parameter logic [5:0]  NOP_FUNCT  = alu_pkg::NOP_FUNCT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [5:0]  rsp_funct,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned MAX_LAT = (DIV_CYCLES > ALU_LAT) ? DIV_CYCLES : ALU_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic [31:0]       r_dataA, w_dataA_nxt;
  logic [31:0]       r_dataB, w_dataB_nxt;
  logic [5:0]        r_signal, w_signal_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]       r_rsp_data, w_rsp_data_nxt;
  logic [5:0]        r_rsp_funct, w_rsp_funct_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_busy, w_busy_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = r_req_ready;
    w_dataA_nxt     = r_dataA;
    w_dataB_nxt     = r_dataB;
    w_signal_nxt    = r_signal;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_funct_nxt = r_rsp_funct;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_dataA_nxt     = req_a;
          w_dataB_nxt     = req_b;
          w_req_ready_nxt = 1'b0;
          if (!funct_supported(req_funct)) begin
            // Never reaches the datapath: Signal stays at NOP.
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = '0;
            w_rsp_funct_nxt = req_funct;
          end else if (funct_is_div(req_funct)) begin
            w_signal_nxt = req_funct;
            w_state_nxt  = DIV_WAIT;
            w_cnt_nxt    = CNT_W'(DIV_CYCLES - 1);
          end else begin
            w_signal_nxt = req_funct;
            w_state_nxt  = EXEC;
            w_cnt_nxt    = CNT_W'(ALU_LAT - 1);
          end
        end
      end

      EXEC: begin
        if (r_cnt == '0) begin
          w_rsp_data_nxt  = alu_result;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_funct_nxt = r_signal;
          w_signal_nxt    = NOP_FUNCT;
          w_state_nxt     = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      DIV_WAIT: begin
        // Hi/Lo are only written inside the datapath; results come back via
        // later MFHI/MFLO requests.
        if (r_cnt == '0) begin
          w_rsp_data_nxt  = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_funct_nxt = r_signal;
          w_signal_nxt    = NOP_FUNCT;
          w_state_nxt     = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      RESP: begin
        // Returning to IDLE re-opens req_ready only from the next edge, so a
        // waiting request is never taken on the handshake edge.
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_dataA     <= '0;
      r_dataB     <= '0;
      r_signal    <= NOP_FUNCT;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_funct <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_dataA     <= w_dataA_nxt;
      r_dataB     <= w_dataB_nxt;
      r_signal    <= w_signal_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_funct <= w_rsp_funct_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign alu_dataA  = r_dataA;
  assign alu_dataB  = r_dataB;
  assign alu_signal = r_signal;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_funct  = r_rsp_funct;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU datapath (registered
// control, combinational result, multi-cycle divider writing Hi/Lo).
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_dataA, alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_funct;
  logic        rsp_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LAT(2), .DIV_CYCLES(34), .NOP_FUNCT(6'b111111)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_funct(rsp_funct), .rsp_err(rsp_err), .busy(busy)
  );

  // Datapath model: ALU control registered, result combinational,
  // divider writes Hi/Lo after 32 edges of DIVU control.
  logic [5:0]  m_ctrl;
  logic [31:0] m_hi, m_lo;
  int          m_dcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl <= 6'b111111;
      m_hi   <= '0;
      m_lo   <= '0;
      m_dcnt <= 0;
    end else begin
      m_ctrl <= alu_signal;
      if (m_ctrl == 6'd27) begin
        m_dcnt <= m_dcnt + 1;
        if (m_dcnt == 31 && alu_dataB != 0) begin
          m_lo <= alu_dataA / alu_dataB;
          m_hi <= alu_dataA % alu_dataB;
        end
      end else begin
        m_dcnt <= 0;
      end
    end
  end

  always_comb begin
    alu_result = '0;
    case (m_ctrl)
      6'd36: alu_result = alu_dataA & alu_dataB;
      6'd37: alu_result = alu_dataA | alu_dataB;
      6'd32: alu_result = alu_dataA + alu_dataB;
      6'd34: alu_result = alu_dataA - alu_dataB;
      6'd42: alu_result = {31'b0, $signed(alu_dataA) < $signed(alu_dataB)};
      6'd0:  alu_result = alu_dataA << alu_dataB[4:0];
      6'd16: alu_result = m_hi;
      6'd18: alu_result = m_lo;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  typedef struct {
    string       nm;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic run_op(input vec_t v);
    int          n;
    logic        held;
    logic [5:0]  sig_exp;
    sig_exp = v.exp_err ? 6'b111111 : v.f;
    @(negedge clk);
    req_valid = 1'b1; req_funct = v.f; req_a = v.a; req_b = v.b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({v.nm, " req_ready low"}, 32'(req_ready), 32'd0);
    chk({v.nm, " busy"}, 32'(busy), 32'd1);
    chk({v.nm, " dataA"}, alu_dataA, v.a);
    n = 0; held = 1'b1;
    while (!rsp_valid && n < 100) begin
      if (alu_signal !== sig_exp || alu_dataA !== v.a || alu_dataB !== v.b) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({v.nm, " latency"}, 32'(n), 32'(v.exp_lat));
    chk({v.nm, " inputs held"}, 32'(held), 32'd1);
    chk({v.nm, " rsp_data"}, rsp_data, v.exp_data);
    chk({v.nm, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({v.nm, " rsp_funct"}, 32'(rsp_funct), 32'(v.f));
    chk({v.nm, " signal nop"}, 32'(alu_signal), 32'h3f);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({v.nm, " rsp_valid clr"}, 32'(rsp_valid), 32'd0);
    chk({v.nm, " req_ready back"}, 32'(req_ready), 32'd1);
    chk({v.nm, " idle"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int   n;
    logic ok_v, ok_d, ok_r, ok_a;
    vec_t v;

    vecs[0] = '{"ADD",      6'd32, 32'd5,   32'd7,   32'd12,         1'b0, 2};
    vecs[1] = '{"SUB",      6'd34, 32'd3,   32'd5,   32'hFFFFFFFE,   1'b0, 2};
    vecs[2] = '{"SLT",      6'd42, 32'd3,   32'd5,   32'd1,          1'b0, 2};
    vecs[3] = '{"AND",      6'd36, 32'hF0,  32'h3C,  32'h30,         1'b0, 2};
    vecs[4] = '{"SLL",      6'd0,  32'd1,   32'd4,   32'd16,         1'b0, 2};
    vecs[5] = '{"MFHI0",    6'd16, 32'd0,   32'd0,   32'd0,          1'b0, 2};
    vecs[6] = '{"DIVU",     6'd27, 32'd100, 32'd7,   32'd0,          1'b0, 34};
    vecs[7] = '{"MFLO",     6'd18, 32'd0,   32'd0,   32'd14,         1'b0, 2};
    vecs[8] = '{"MFHI",     6'd16, 32'd0,   32'd0,   32'd2,          1'b0, 2};
    vecs[9] = '{"BADFN",    6'd7,  32'd9,   32'd9,   32'd0,          1'b1, 0};

    reset = 1'b1; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst signal", 32'(alu_signal), 32'h3f);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    @(negedge clk); reset = 1'b0;

    // rsp_ready without a response does nothing
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; rsp_ready = 1'b0;
    chk("stray rsp_ready valid", 32'(rsp_valid), 32'd0);
    chk("stray rsp_ready busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Backpressure: response held, later request not taken early
    @(negedge clk);
    req_valid = 1'b1; req_funct = 6'd37; req_a = 32'hF0; req_b = 32'h0F;
    @(posedge clk); #1;
    req_funct = 6'd36; req_a = 32'hFF; req_b = 32'h0F;
    wait_rsp(n);
    chk("BP latency", 32'(n), 32'd2);
    ok_v = 1; ok_d = 1; ok_r = 1; ok_a = 1;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b1) ok_v = 0;
      if (rsp_data !== 32'hFF) ok_d = 0;
      if (req_ready !== 1'b0) ok_r = 0;
      if (alu_dataA !== 32'hF0) ok_a = 0;
      @(posedge clk); #1;
    end
    chk("BP valid held", 32'(ok_v), 32'd1);
    chk("BP data held", 32'(ok_d), 32'd1);
    chk("BP req_ready low", 32'(ok_r), 32'd1);
    chk("BP operands kept", 32'(ok_a), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("BP no same-edge accept", 32'(alu_signal), 32'h3f);
    chk("BP req_ready reopen", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("BP2 accepted signal", 32'(alu_signal), 32'd36);
    chk("BP2 accepted dataA", alu_dataA, 32'hFF);
    wait_rsp(n);
    chk("BP2 data", rsp_data, 32'h0F);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("BP2 done", 32'(busy), 32'd0);

    // Reset during a divide
    @(negedge clk);
    req_valid = 1'b1; req_funct = 6'd27; req_a = 32'd50; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3; reset = 1'b1;
    #1;
    chk("RST signal", 32'(alu_signal), 32'h3f);
    chk("RST rsp_valid", 32'(rsp_valid), 32'd0);
    chk("RST busy", 32'(busy), 32'd0);
    chk("RST req_ready", 32'(req_ready), 32'd1);
    chk("RST dataA", alu_dataA, 32'd0);
    @(negedge clk); reset = 1'b0;
    v = '{"MFLO after rst", 6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 2};
    run_op(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issuing end of the ALU datapath interface: accepts operation requests (funct code plus two 32-bit operands) over a valid/ready handshake and drives the datapath's dataA/dataB/Signal inputs.
- Holds those inputs for the operation's required latency, which is multi-cycle for DIVU, then captures Output.
- Returns the result over a valid/ready response channel.
- Sits between a test/CPU front end and the top-level ALU datapath, sharing its clock and reset.

Parameters:
- ALU_LAT, 2: edges from issue to a valid Output for AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO. One edge is for the registered ALU control; one is for the combinational result.
- DIV_CYCLES, 34: edges Signal is held at DIVU before Hi/Lo are guaranteed written.
- NOP_FUNCT, 6'b111111: funct driven while idle. It is decoded by no datapath unit, so the divider does not restart.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_funct  in  6  operation code (36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 0 SLL, 27 DIVU, 16 MFHI, 18 MFLO)
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_dataA  out  32  to datapath dataA
- alu_dataB  out  32  to datapath dataB
- alu_signal  out  6  to datapath Signal
- alu_result  in  32  from datapath Output
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  result
- rsp_funct  out  6  funct of the completed operation
- rsp_err  out  1  unsupported funct
- busy  out  1  high in any state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1; rsp_valid=0; rsp_data=0; rsp_funct=0; rsp_err=0; busy=0; alu_dataA=0; alu_dataB=0; alu_signal=NOP_FUNCT; state=IDLE; cnt=0.
- States: IDLE, EXEC, DIV_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge T0: latch funct/a/b into the alu_* outputs; req_ready drops to 0.
  - Supported non-DIVU funct -> EXEC, cnt=ALU_LAT-1.
  - DIVU -> DIV_WAIT, cnt=DIV_CYCLES-1.
  - Unsupported funct -> RESP directly with rsp_err=1, rsp_data=0, alu_signal stays NOP_FUNCT.
- EXEC:
  - cnt decrements each edge.
  - On the edge where cnt==0 (edge T0+ALU_LAT): rsp_data<=alu_result, rsp_valid<=1, alu_signal<=NOP_FUNCT, go to RESP.
- DIV_WAIT:
  - alu_signal held at DIVU; cnt decrements.
  - On cnt==0 (edge T0+DIV_CYCLES): alu_signal<=NOP_FUNCT, rsp_data<=0, rsp_valid<=1, go to RESP.
  - Quotient and remainder are read by separate MFLO/MFHI requests.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid<=0, rsp_err<=0, req_ready<=1, go to IDLE.
  - No new request is accepted in the same edge; throughput is one operation per ALU_LAT+2 edges minimum.
- Operands and funct must not change on alu_* between issue and capture. A req_* change while busy is ignored.
- MFHI/MFLO with no prior DIVU since reset returns 0, the datapath's Hi/Lo reset value. This is not an error.
- DIVU with req_b=0 is issued normally. The result is whatever the divider writes; the sequencer does not check it.
- Reset asserted mid-operation (any state): all outputs return to reset values immediately. Any pending response is discarded. The datapath is reset by the same signal.
- rsp_ready high while rsp_valid=0 has no effect.

Decomposition:
- Shared package alu_pkg:
  - funct constants AND/OR/ADD/SUB/SLT/SLL/DIVU/MFHI/MFLO/NOP_FUNCT;
  - state enum;
  - a funct-is-supported / funct-is-divide classification function, reused by ALUControl.
- No sub-module needed.
  - Optional natural split: alu_op_latency_cnt (down-counter with load and zero flag).

Test Plan:
- ADD a=5, b=7, rsp_ready=1 -> alu_signal=32 for 2 edges; rsp_valid at T0+2; rsp_data=12, rsp_err=0; then alu_signal=NOP_FUNCT, req_ready=1.
- SUB a=3, b=5, then SLT a=3, b=5 -> rsp_data=0xFFFFFFFE, then rsp_data=1.
- DIVU a=100, b=7; then MFLO; then MFHI -> DIVU response rsp_data=0 at T0+34 with alu_signal=27 throughout; MFLO returns 14; MFHI returns 2.
- OR a=0xF0, b=0x0F with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_data=0xFF stable; req_ready=0; a second req_valid is not accepted until after the rsp_ready handshake.
- funct=6'b000111 -> rsp_err=1, rsp_data=0, alu_signal never leaves NOP_FUNCT.
- DIVU a=50, b=3, reset pulsed at T0+10 -> state IDLE, alu_signal=NOP_FUNCT, rsp_valid=0 immediately; a subsequent MFLO returns 0.
